// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD framebuffer scheduler.
package lcd_pkg;

    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;
    localparam int ADDR_W_DEF   = 17;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // RGB565 field positions within a pixel word
    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

endpackage

// File: rtl/lcd_line_buffer.sv
// Ping-pong line store: two banks of H_ACTIVE RGB565 words, one write port,
// one read port with registered read data.
module lcd_line_buffer #(
    parameter int H_ACTIVE = 480,
    parameter int IDX_W    = $clog2(H_ACTIVE + 1)
) (
    input  logic             PixelClk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [15:0]      wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [15:0]      rd_data
);

    logic [15:0] ram [0:1][0:H_ACTIVE-1];

    always_ff @(posedge PixelClk) begin
        if (wr_en)
            ram[wr_bank][wr_idx] <= wr_data;
        rd_data <= ram[rd_bank][rd_idx];
    end

endmodule

// File: rtl/lcd_fb_scheduler.sv
// Arbitrates a single-port RGB565 framebuffer between one-line-ahead display
// prefetch (always wins) and host writes, and streams pixels out on DE.
module lcd_fb_scheduler
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              frame_start,
    input  logic              line_req,
    input  logic              de,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    output logic              host_gnt,
    output logic [15:0]       pix_rgb,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int CNT_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic [CNT_W-1:0]  H_CNT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] V_CNT  = LINE_W'(V_ACTIVE);

    fetch_state_e state, state_nxt;

    logic                    fetch_pending;
    logic                    fill_bank;
    logic                    disp_bank;
    logic                    fetch_bank;
    logic [LINE_W-1:0]       line_idx;
    logic [ADDR_W-1:0]       base;
    logic [CNT_W-1:0]        fcnt;
    logic [CNT_W-1:0]        rd_ptr;
    logic [1:0]              vld_pipe;
    logic [1:0][CNT_W-1:0]   idx_pipe;
    logic                    issue;
    logic                    done;
    logic                    line_evt;
    logic                    cap_en;
    logic                    pix_en;
    logic [CNT_W-1:0]        buf_rd_idx;
    logic [15:0]             buf_rdata;

    assign line_evt   = line_req & ~frame_start;
    assign host_gnt   = host_req & (state == ST_IDLE) & ~fetch_pending & ~frame_start & ~line_req;
    // vld_pipe[0] is the registered read strobe, vld_pipe[1] marks rdata valid
    assign mem_rd     = vld_pipe[0];
    assign cap_en     = vld_pipe[1] & (state == ST_FETCH) & ~frame_start;
    assign buf_rd_idx = (rd_ptr < H_CNT) ? rd_ptr : '0;
    assign pix_rgb    = pix_en ? buf_rdata : 16'h0000;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch_pending) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                issue = (fcnt < H_CNT);
                if (vld_pipe[1] && idx_pipe[1] == H_LAST) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (frame_start) begin
            state_nxt = ST_IDLE;
            issue     = 1'b0;
            done      = 1'b0;
        end
    end

    // Fetch datapath, line/bank bookkeeping and the memory port registers
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            fetch_pending <= 1'b0;
            fill_bank     <= 1'b0;
            disp_bank     <= 1'b1;
            fetch_bank    <= 1'b0;
            line_idx      <= '0;
            base          <= '0;
            fcnt          <= '0;
            vld_pipe      <= '0;
            idx_pipe      <= '0;
            mem_addr      <= '0;
            mem_wr        <= 1'b0;
            mem_wdata     <= '0;
            underrun      <= 1'b0;
        end else begin
            vld_pipe    <= frame_start ? 2'b00 : {vld_pipe[0], issue};
            idx_pipe[0] <= fcnt;
            idx_pipe[1] <= idx_pipe[0];

            if (state != ST_FETCH) fcnt <= '0;
            else if (issue)        fcnt <= fcnt + CNT_W'(1);

            if (issue)         mem_addr <= base + ADDR_W'(fcnt);
            else if (host_gnt) mem_addr <= host_addr;
            mem_wr <= host_gnt;
            if (host_gnt) mem_wdata <= host_wdata;

            if (state == ST_IDLE && fetch_pending) fetch_bank <= fill_bank;

            if (frame_start) begin
                fetch_pending <= 1'b1;
                fill_bank     <= 1'b0;
                disp_bank     <= 1'b1;
                line_idx      <= '0;
                base          <= '0;
            end else begin
                if (line_evt) begin
                    fill_bank <= ~fill_bank;
                    disp_bank <= ~disp_bank;
                    if (line_idx < V_CNT) fetch_pending <= 1'b1;
                end else if (state == ST_IDLE && fetch_pending) begin
                    fetch_pending <= 1'b0;
                end
                if (done) begin
                    base     <= base + ADDR_W'(H_ACTIVE);
                    line_idx <= line_idx + LINE_W'(1);
                end
            end

            if (line_evt && state == ST_FETCH) underrun <= 1'b1;
            else if (underrun_clr)             underrun <= 1'b0;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= de & (rd_ptr < H_CNT);
            if (line_evt)                    rd_ptr <= '0;
            else if (de && (rd_ptr < H_CNT)) rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    lcd_line_buffer #(
        .H_ACTIVE (H_ACTIVE),
        .IDX_W    (CNT_W)
    ) u_line_buf (
        .PixelClk (PixelClk),
        .wr_en    (cap_en),
        .wr_bank  (fetch_bank),
        .wr_idx   (idx_pipe[1]),
        .wr_data  (mem_rdata),
        .rd_bank  (disp_bank),
        .rd_idx   (buf_rd_idx),
        .rd_data  (buf_rdata)
    );

endmodule

// File: tb/tb_lcd_fb_scheduler.sv
// Directed bench: a full-size instance for fetch/pixel/host/underrun/abort
// behaviour and a short-line instance for whole-frame line counting.
module tb_lcd_fb_scheduler;

    localparam int AW = 17;

    logic PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;

    logic          nRST;
    logic          frame_start, line_req, de, host_req, underrun_clr;
    logic [AW-1:0] host_addr, mem_addr;
    logic [15:0]   host_wdata, mem_wdata, mem_rdata, pix_rgb;
    logic          mem_rd, mem_wr, host_gnt, underrun;

    logic          s_frame_start, s_line_req, s_de, s_host_req, s_underrun_clr;
    logic [AW-1:0] s_host_addr, s_mem_addr;
    logic [15:0]   s_host_wdata, s_mem_wdata, s_mem_rdata, s_pix_rgb;
    logic          s_mem_rd, s_mem_wr, s_host_gnt, s_underrun;

    lcd_fb_scheduler #(.H_ACTIVE(480), .V_ACTIVE(272), .ADDR_W(AW)) u_dut (
        .PixelClk(PixelClk), .nRST(nRST), .frame_start(frame_start), .line_req(line_req),
        .de(de), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .host_req(host_req), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .pix_rgb(pix_rgb),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    lcd_fb_scheduler #(.H_ACTIVE(16), .V_ACTIVE(272), .ADDR_W(AW)) u_dut_s (
        .PixelClk(PixelClk), .nRST(nRST), .frame_start(s_frame_start), .line_req(s_line_req),
        .de(s_de), .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .host_req(s_host_req),
        .host_addr(s_host_addr), .host_wdata(s_host_wdata), .host_gnt(s_host_gnt),
        .pix_rgb(s_pix_rgb), .underrun(s_underrun), .underrun_clr(s_underrun_clr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Framebuffer model: word a preloaded with a, 1-cycle read latency
    logic [15:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i);
        mem_rdata = '0;
        forever begin
            @(posedge PixelClk);
            if (mem_wr) mem[mem_addr] = mem_wdata;
            if (mem_rd) mem_rdata <= mem[mem_addr];
        end
    end

    initial begin
        s_mem_rdata = '0;
        forever begin
            @(posedge PixelClk);
            if (s_mem_rd) s_mem_rdata <= 16'(s_mem_addr);
        end
    end

    // Read-burst monitors: start address and length of every fetch
    int nf = 0, rd_total = 0, seq_err = 0, both_err = 0;
    int fbase [16];
    int flen  [16];
    logic rd_prev = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    initial forever begin
        @(negedge PixelClk);
        if (mem_rd) begin
            rd_total++;
            if (!rd_prev) begin
                if (nf < 16) begin
                    fbase[nf] = int'(mem_addr);
                    flen[nf]  = 0;
                end
                nf++;
            end else if (mem_addr != prev_addr + AW'(1)) begin
                seq_err++;
            end
            if (nf <= 16) flen[nf-1]++;
            prev_addr = mem_addr;
        end
        if (mem_rd && mem_wr) both_err++;
        rd_prev = mem_rd;
    end

    int s_nf = 0, s_last_base = -1;
    logic s_rd_prev = 1'b0;
    initial forever begin
        @(negedge PixelClk);
        if (s_mem_rd && !s_rd_prev) begin
            s_nf++;
            s_last_base = int'(s_mem_addr);
        end
        s_rd_prev = s_mem_rd;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PixelClk);
            #1;
        end
    endtask

    task automatic wait_len(input int idx, input int target);
        bit hit = 0;
        for (int i = 0; i < 700 && !hit; i++) begin
            @(negedge PixelClk);
            #1;
            if (nf == idx + 1 && flen[idx] >= target) hit = 1;
        end
        if (!hit) chk("wait_fetch_len_timeout", 32'(flen[idx]), 32'(target));
    endtask

    initial begin
        int k;
        bit got;
        nRST = 0; frame_start = 0; line_req = 0; de = 0; host_req = 0; underrun_clr = 0;
        host_addr = '0; host_wdata = '0;
        s_frame_start = 0; s_line_req = 0; s_de = 0; s_host_req = 0; s_underrun_clr = 0;
        s_host_addr = '0; s_host_wdata = '0;
        tick(3);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_pix", 32'(pix_rgb), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_s_mem_rd", 32'(s_mem_rd), 0);
        nRST = 1;
        tick(1);

        // idle host write right after reset: nothing pending
        host_req = 1; host_addr = 17'h1FFF0; host_wdata = 16'h1234;
        #1 chk("gnt_idle", 32'(host_gnt), 1);
        tick(1);
        host_req = 0;
        chk("wr_idle", 32'(mem_wr), 1);
        chk("wr_idle_addr", 32'(mem_addr), 32'h1FFF0);
        chk("wr_idle_data", 32'(mem_wdata), 32'h1234);
        tick(1);
        chk("wr_idle_drop", 32'(mem_wr), 0);

        // frame_start prefetch with host held off until it ends
        frame_start = 1; host_req = 1; host_addr = 17'h1F000; host_wdata = 16'hBEEF;
        #1 chk("gnt_fs", 32'(host_gnt), 0);
        tick(1);
        frame_start = 0;
        k = 0; got = 0;
        while (k < 600 && !got) begin
            @(negedge PixelClk);
            if (host_gnt) got = 1;
            else begin
                @(posedge PixelClk);
                #1;
                k++;
            end
        end
        chk("gnt_wait_cycles", 32'(k), 483);
        chk("wr_before_gnt", 32'(mem_wr), 0);
        chk("f0_rd_total", 32'(rd_total), 480);
        chk("f0_count", 32'(nf), 1);
        chk("f0_base", 32'(fbase[0]), 0);
        chk("f0_len", 32'(flen[0]), 480);
        tick(1);
        host_req = 0;
        chk("wr_after_fetch", 32'(mem_wr), 1);
        chk("wr_after_fetch_addr", 32'(mem_addr), 32'h1F000);
        chk("wr_after_fetch_data", 32'(mem_wdata), 32'hBEEF);
        tick(1);
        chk("wr_after_fetch_drop", 32'(mem_wr), 0);

        // back-to-back host writes
        host_req = 1; host_addr = 17'h1E000; host_wdata = 16'h0011;
        tick(1);
        host_addr = 17'h1E001; host_wdata = 16'h0022;
        chk("wr_b2b_0", 32'(mem_wr), 1);
        chk("wr_b2b_0_addr", 32'(mem_addr), 32'h1E000);
        tick(1);
        host_req = 0;
        chk("wr_b2b_1", 32'(mem_wr), 1);
        chk("wr_b2b_1_addr", 32'(mem_addr), 32'h1E001);
        chk("wr_b2b_1_data", 32'(mem_wdata), 32'h0022);

        // display line 0 while line 1 is fetched
        line_req = 1;
        tick(1);
        line_req = 0; de = 1;
        for (int j = 0; j < 482; j++) begin
            tick(1);
            chk($sformatf("pix_%0d", j), 32'(pix_rgb), (j < 480) ? 32'(j) : 32'd0);
        end
        de = 0;
        tick(1);
        chk("pix_de_low", 32'(pix_rgb), 0);
        tick(30);
        chk("f1_count", 32'(nf), 2);
        chk("f1_base", 32'(fbase[1]), 480);
        chk("f1_len", 32'(flen[1]), 480);
        chk("no_underrun", 32'(underrun), 0);

        // line_req 100 words into a fetch
        line_req = 1;
        tick(1);
        line_req = 0;
        wait_len(2, 100);
        line_req = 1;
        tick(1);
        line_req = 0;
        chk("underrun_set", 32'(underrun), 1);
        tick(1000);
        chk("f3_count", 32'(nf), 4);
        chk("f2_base", 32'(fbase[2]), 960);
        chk("f2_len", 32'(flen[2]), 480);
        chk("f3_base", 32'(fbase[3]), 1440);
        chk("f3_len", 32'(flen[3]), 480);
        chk("underrun_sticky", 32'(underrun), 1);
        underrun_clr = 1;
        tick(1);
        underrun_clr = 0;
        chk("underrun_clr", 32'(underrun), 0);

        // frame_start aborts a fetch at word 200
        line_req = 1;
        tick(1);
        line_req = 0;
        wait_len(4, 200);
        frame_start = 1;
        tick(1);
        frame_start = 0;
        tick(520);
        chk("f5_count", 32'(nf), 6);
        chk("f4_base", 32'(fbase[4]), 1920);
        chk("f4_abort_len", 32'(flen[4]), 200);
        chk("f5_base", 32'(fbase[5]), 0);
        chk("f5_len", 32'(flen[5]), 480);
        line_req = 1;
        tick(1);
        line_req = 0;
        tick(500);
        chk("f6_count", 32'(nf), 7);
        chk("f6_base", 32'(fbase[6]), 480);
        chk("seq_err", 32'(seq_err), 0);
        chk("rd_wr_overlap", 32'(both_err), 0);

        // full frame on the short-line instance
        s_frame_start = 1;
        tick(1);
        s_frame_start = 0;
        tick(26);
        chk("s_prefetch_count", 32'(s_nf), 1);
        chk("s_prefetch_base", 32'(s_last_base), 0);
        for (int i = 1; i <= 271; i++) begin
            s_line_req = 1;
            tick(1);
            s_line_req = 0;
            tick(26);
        end
        chk("s_frame_count", 32'(s_nf), 272);
        chk("s_last_base", 32'(s_last_base), 271 * 16);
        chk("s_no_underrun", 32'(s_underrun), 0);
        for (int i = 272; i <= 273; i++) begin
            s_line_req = 1;
            tick(1);
            s_line_req = 0;
            tick(26);
            chk($sformatf("s_no_fetch_lr%0d", i), 32'(s_nf), 272);
        end

        // frame_start beats a simultaneous line_req
        s_frame_start = 1; s_line_req = 1;
        tick(1);
        s_frame_start = 0; s_line_req = 0;
        tick(26);
        chk("s_fs_lr_count", 32'(s_nf), 273);
        chk("s_fs_lr_base", 32'(s_last_base), 0);
        s_line_req = 1;
        tick(1);
        s_line_req = 0;
        tick(26);
        chk("s_line1_base", 32'(s_last_base), 16);

        // set beats clear on underrun
        s_line_req = 1;
        tick(1);
        s_line_req = 0;
        tick(3);
        s_line_req = 1; s_underrun_clr = 1;
        tick(1);
        s_line_req = 0; s_underrun_clr = 0;
        chk("s_underrun_set_wins", 32'(s_underrun), 1);
        s_underrun_clr = 1;
        tick(1);
        s_underrun_clr = 0;
        chk("s_underrun_clr", 32'(s_underrun), 0);
        tick(60);
        chk("s_pix_idle", 32'(s_pix_rgb), 0);
        s_host_req = 1; s_host_addr = 17'h00123; s_host_wdata = 16'h5A5A;
        #1 chk("s_gnt_idle", 32'(s_host_gnt), 1);
        tick(1);
        s_host_req = 0;
        chk("s_wr", 32'(s_mem_wr), 1);
        chk("s_wr_addr", 32'(s_mem_addr), 32'h123);
        chk("s_wr_data", 32'(s_mem_wdata), 32'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
